// File: rtl/onehot_decoder_seq.sv
// Sequenced binary-to-one-hot decoder. Codes arrive over valid/ready into a
// small FIFO. Each code is driven as a registered one-hot word for HOLD
// cycles, followed by GAP idle cycles.
module onehot_decoder_seq #(
    parameter int unsigned CW    = 2,
    parameter int unsigned HOLD  = 3,
    parameter int unsigned GAP   = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CW-1:0]      in_code,
    input  logic               in_en,
    output logic [2**CW-1:0]   y,
    output logic               y_valid,
    output logic               busy
);

    localparam int unsigned OUT_W   = 2**CW;
    localparam int unsigned ENT_W   = CW + 1;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // FSM state and registered outputs
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load;
    logic             clear;
    logic [ENT_W-1:0] head;
    logic [OUT_W-1:0] head_word;
    logic [OUT_W-1:0] y_nxt;
    logic             y_valid_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full && !flush;
    assign head      = mem[rd_ptr];
    assign head_word = head[CW] ? (OUT_W'(1) << head[CW-1:0]) : '0;
    assign busy      = (state != ST_IDLE) || !empty;

    // FIFO data write; payload needs no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_en, in_code};
        end
    end

    // FIFO pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // State register together with counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            y_valid <= y_valid_nxt;
        end
    end

    // Next-state logic: decides pops, word loads and output clears
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            clear     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        cnt_nxt   = HOLD_M1;
                        state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else if (GAP > 0) begin
                        clear     = 1'b1;
                        cnt_nxt   = GAP_M1;
                        state_nxt = ST_GAP;
                    end else if (!empty) begin
                        // back-to-back words with no idle cycle
                        pop     = 1'b1;
                        load    = 1'b1;
                        cnt_nxt = HOLD_M1;
                    end else begin
                        clear     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else if (!empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        cnt_nxt   = HOLD_M1;
                        state_nxt = ST_DRIVE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output logic: next values for the registered one-hot word
    always_comb begin
        y_nxt       = y;
        y_valid_nxt = y_valid;
        if (load) begin
            y_nxt       = head_word;
            y_valid_nxt = 1'b1;
        end else if (clear) begin
            y_nxt       = '0;
            y_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (HOLD=3/GAP=1 and HOLD=1/GAP=0)
// share one input stream; a timeline-based reference model predicts outputs.
module tb_onehot_decoder_seq;

    localparam int DEPTH = 2;
    localparam int NI    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_en;

    logic [3:0] y_o    [NI];
    logic       yv_o   [NI];
    logic       rdy_o  [NI];
    logic       busy_o [NI];

    onehot_decoder_seq #(.CW(2), .HOLD(3), .GAP(1), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .in_code(in_code), .in_en(in_en),
        .y(y_o[0]), .y_valid(yv_o[0]), .busy(busy_o[0])
    );

    onehot_decoder_seq #(.CW(2), .HOLD(1), .GAP(0), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .in_code(in_code), .in_en(in_en),
        .y(y_o[1]), .y_valid(yv_o[1]), .busy(busy_o[1])
    );

    always #5 clk = ~clk;

    // reference model: FIFO contents plus a timeline of when the current
    // word stops being driven and when the next pop becomes possible
    int hold_c [NI] = '{3, 1};
    int gap_c  [NI] = '{1, 0};
    int qn        [NI];
    int qw        [NI][DEPTH];
    int cur       [NI];
    int drive_end [NI];
    int free_at   [NI];
    bit acc       [NI];
    int cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            qn[i]        = 0;
            cur[i]       = 0;
            drive_end[i] = cyc;
            free_at[i]   = cyc;
            acc[i]       = 1'b0;
        end
    endtask

    task automatic model_edge();
        int  word;
        bit  do_pop;
        bit  do_push;
        word = in_en ? (2 ** in_code) : 0;
        for (int i = 0; i < NI; i++) begin
            acc[i] = 1'b0;
            if (flush) begin
                qn[i]        = 0;
                drive_end[i] = cyc;
                free_at[i]   = cyc;
            end else begin
                do_pop  = (qn[i] > 0) && (cyc >= free_at[i]);
                do_push = in_valid && (qn[i] < DEPTH);
                if (do_pop) begin
                    cur[i] = qw[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) qw[i][k] = qw[i][k+1];
                    qn[i]--;
                    drive_end[i] = cyc + hold_c[i];
                    free_at[i]   = cyc + hold_c[i] + gap_c[i];
                end
                if (do_push) begin
                    qw[i][qn[i]] = word;
                    qn[i]++;
                    acc[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit valid;
        for (int i = 0; i < NI; i++) begin
            valid = (cyc < drive_end[i]);
            check($sformatf("y%0d", i),       32'(y_o[i]),    valid ? 32'(cur[i]) : 32'd0);
            check($sformatf("y_valid%0d", i), 32'(yv_o[i]),   32'(valid));
            check($sformatf("busy%0d", i),    32'(busy_o[i]), 32'((cyc < free_at[i]) || (qn[i] > 0)));
            check($sformatf("in_ready%0d", i),32'(rdy_o[i]),  32'(qn[i] < DEPTH));
        end
    endtask

    task automatic step(input logic v, input logic [1:0] c, input logic e, input logic f);
        in_valid = v;
        in_code  = c;
        in_en    = e;
        flush    = f;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // hold a code on the input until instance 0 accepts it (bounded)
    task automatic push_wait(input logic [1:0] c, input logic e);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b1, c, e, 1'b0);
            done = acc[0];
        end
        check("push_accept", 32'(done), 32'd1);
    endtask

    task automatic check_all_clear(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_y%0d", tag, i),    32'(y_o[i]),    32'd0);
            check($sformatf("%s_yv%0d", tag, i),   32'(yv_o[i]),   32'd0);
            check($sformatf("%s_busy%0d", tag, i), 32'(busy_o[i]), 32'd0);
            check($sformatf("%s_rdy%0d", tag, i),  32'(rdy_o[i]),  32'd1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_code  = 2'd0;
        in_en    = 1'b0;
        model_reset();
        #3;
        check_all_clear("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        #1;

        // single word, then back-to-back burst filling the FIFO
        push_wait(2'b10, 1'b1);
        idle(6);
        push_wait(2'b00, 1'b1);
        push_wait(2'b11, 1'b1);
        push_wait(2'b01, 1'b1);
        idle(16);

        // disabled request decodes to an all-zero but valid word
        push_wait(2'b11, 1'b0);
        idle(6);

        // flush while driving with words queued
        push_wait(2'b10, 1'b1);
        push_wait(2'b00, 1'b1);
        push_wait(2'b01, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check_all_clear("flush");
        idle(8);

        // asynchronous reset in the middle of a driven word
        push_wait(2'b11, 1'b1);
        idle(1);
        check("pre_reset_y0", 32'(y_o[0]), 32'h8);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_clear("async_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        #1;
        idle(6);

        // consecutive words (back-to-back on the HOLD=1/GAP=0 instance)
        step(1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b1, 1'b0);
        idle(6);

        // randomized traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
